// File: rtl/sign_demux_if.sv
// sign_demux_if: valid/ready bus between a noise source and a sign/magnitude consumer
//   in_valid  : in_data holds a sample
//   in_ready  : receiver can accept a sample this cycle
//   in_data   : 16-bit two's-complement sample
//   out_valid : out_sign/out_mag hold a decoded sample
//   out_ready : downstream takes the decoded sample this cycle
//   out_sign  : 1 = negative
//   out_mag   : 16-bit unsigned magnitude
interface sign_demux_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [15:0] out_mag;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_mag
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_mag
    );
endinterface

// File: rtl/sign_demux.sv
// sign_demux: decode two's-complement noise samples into sign/magnitude, buffer in a FIFO, count signs
//   clk     : system clock, rising edge
//   rst     : synchronous active-low reset
//   bus     : sign_demux_if.slave (sample in, decoded sample out, valid/ready both sides)
//   clr_cnt : synchronous clear of both counters, wins over a same-cycle pop
//   pos_cnt : saturating count of popped samples with sign 0
//   neg_cnt : saturating count of popped samples with sign 1
module sign_demux #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    sign_demux_if.slave      bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] pos_cnt,
    output logic [CNT_W-1:0] neg_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt, next_cnt;
    logic          rdy, push, pop;
    logic [16:0]   head, entry;
    always_comb begin
        head     = mem[rp];
        push     = bus.in_valid && rdy;
        pop      = (cnt != '0) && bus.out_ready;
        next_cnt = cnt + (AW+1)'(push) - (AW+1)'(pop);
        // -0x8000 wraps back to 0x8000, which is exactly the unsigned magnitude
        entry    = {bus.in_data[15], bus.in_data[15] ? 16'(~bus.in_data + 16'd1) : bus.in_data};
    end
    assign bus.in_ready  = rdy;
    assign bus.out_valid = cnt != '0;
    assign bus.out_sign  = head[16];
    assign bus.out_mag   = head[15:0];
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            wp      <= '0;
            rp      <= '0;
            rdy     <= 1'b0;
            pos_cnt <= '0;
            neg_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= entry;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= next_cnt;
            // registered ready: looks at occupancy after this edge, so a full FIFO stalls one cycle
            rdy <= next_cnt < (AW+1)'(DEPTH);
            if (clr_cnt) begin
                pos_cnt <= '0;
                neg_cnt <= '0;
            end else if (pop) begin
                if (head[16]) begin
                    if (neg_cnt != '1) neg_cnt <= neg_cnt + 1'b1;
                end else if (pos_cnt != '1) begin
                    pos_cnt <= pos_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sign_demux.sv
// tb_sign_demux: randomized and directed checks of sign_demux against a queue-based model
module tb_sign_demux;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;
    logic clk = 0;
    logic rst = 0;
    logic clr_cnt = 0;
    logic [CW-1:0] pos_cnt, neg_cnt;
    sign_demux_if bus();
    sign_demux #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .clr_cnt(clr_cnt),
        .pos_cnt(pos_cnt), .neg_cnt(neg_cnt)
    );
    always #5 clk = ~clk;
    int total = 0;
    int passed = 0;
    logic [16:0] q[$];
    int  mp = 0, mn = 0;
    bit  mr = 0;
    bit  started = 0;
    bit  m_push, m_pop;
    logic [16:0] m_head;
    task automatic chk(string n, int a, int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask
    function automatic logic [16:0] decode(logic [15:0] d);
        int v = $signed(d);
        int m = v < 0 ? -v : v;
        return {v < 0, 16'(m)};
    endfunction
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            mp = 0; mn = 0; mr = 0;
        end else begin
            m_push = bus.in_valid && mr;
            m_pop  = q.size() != 0 && bus.out_ready;
            m_head = '0;
            if (m_pop) m_head = q.pop_front();
            if (clr_cnt) begin
                mp = 0; mn = 0;
            end else if (m_pop) begin
                if (m_head[16]) mn = mn == CMAX ? CMAX : mn + 1;
                else mp = mp == CMAX ? CMAX : mp + 1;
            end
            if (m_push) q.push_back(decode(bus.in_data));
            mr = q.size() < DEPTH;
        end
        started = 1;
    end
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", bus.out_valid, q.size() != 0);
            chk("in_ready", bus.in_ready, mr);
            chk("pos_cnt", pos_cnt, mp);
            chk("neg_cnt", neg_cnt, mn);
            if (q.size() != 0) begin
                chk("out_sign", bus.out_sign, q[0][16]);
                chk("out_mag", bus.out_mag, q[0][15:0]);
            end
        end
    end
    task automatic tick();
        @(negedge clk);
    endtask
    logic [15:0] dec_in [5] = '{16'hAF0C, 16'h50F4, 16'h8000, 16'h0000, 16'hFFFF};
    logic        dec_s  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] dec_m  [5] = '{16'h50F4, 16'h50F4, 16'h8000, 16'h0000, 16'h0001};
    initial begin
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
        repeat (2) tick();
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst in_ready", bus.in_ready, 0);
        chk("rst out_sign", bus.out_sign, 0);
        chk("rst out_mag", bus.out_mag, 0);
        chk("rst pos_cnt", pos_cnt, 0);
        chk("rst neg_cnt", neg_cnt, 0);
        rst = 1;
        chk("first cycle in_ready", bus.in_ready, 0);
        tick();
        chk("post rst in_ready", bus.in_ready, 1);
        // decode set, streaming
        bus.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1; bus.in_data = dec_in[i];
            tick();
            chk("dec sign", bus.out_sign, dec_s[i]);
            chk("dec mag", bus.out_mag, dec_m[i]);
        end
        bus.in_valid = 0;
        tick();
        chk("dec pos_cnt", pos_cnt, 2);
        chk("dec neg_cnt", neg_cnt, 3);
        // latency into empty FIFO
        bus.out_ready = 0; bus.in_valid = 1; bus.in_data = 16'h1234;
        tick();
        bus.in_valid = 0;
        chk("lat valid", bus.out_valid, 1);
        chk("lat mag", bus.out_mag, 16'h1234);
        chk("lat sign", bus.out_sign, 0);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        // back-pressure and wrap
        bus.in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 16'(17 * (i + 1));
            tick();
        end
        chk("bp full in_ready", bus.in_ready, 0);
        bus.in_data = 16'h0055;
        repeat (2) tick();
        chk("bp held in_ready", bus.in_ready, 0);
        chk("bp head", bus.out_mag, 16'h0011);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("bp ready back", bus.in_ready, 1);
        chk("bp head after pop", bus.out_mag, 16'h0022);
        tick();
        bus.in_valid = 0;
        chk("bp 5th accepted", q.size(), 4);
        bus.out_ready = 1;
        repeat (5) tick();
        // simultaneous push/pop at count 2
        bus.out_ready = 0; bus.in_valid = 1;
        repeat (2) begin
            bus.in_data = 16'($urandom);
            tick();
        end
        bus.out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 16'($urandom);
            tick();
            chk("pp count", q.size(), 2);
        end
        bus.in_valid = 0;
        repeat (3) tick();
        // counter saturation
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        chk("clr pos", pos_cnt, 0);
        chk("clr neg", neg_cnt, 0);
        bus.in_valid = 1;
        for (int i = 0; i < 9; i++) begin
            bus.in_data = 16'h8000 | 16'($urandom);
            tick();
        end
        bus.in_valid = 0;
        tick();
        chk("sat neg", neg_cnt, 7);
        chk("sat pos", pos_cnt, 0);
        bus.in_valid = 1; bus.in_data = 16'h0005;
        tick();
        bus.in_valid = 0; clr_cnt = 1;
        tick();
        clr_cnt = 0;
        chk("clr wins pos", pos_cnt, 0);
        chk("clr wins neg", neg_cnt, 0);
        // reset mid-operation
        bus.out_ready = 0; bus.in_valid = 1;
        repeat (3) begin
            bus.in_data = 16'($urandom);
            tick();
        end
        rst = 0; bus.out_ready = 1;
        tick();
        chk("mid rst valid", bus.out_valid, 0);
        chk("mid rst ready", bus.in_ready, 0);
        chk("mid rst sign", bus.out_sign, 0);
        chk("mid rst mag", bus.out_mag, 0);
        rst = 1; bus.in_valid = 0; bus.out_ready = 0;
        chk("mid rel ready", bus.in_ready, 0);
        tick();
        chk("mid rel ready up", bus.in_ready, 1);
        chk("mid no stale", bus.out_valid, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.in_data   = 16'($urandom);
            bus.out_ready = $urandom_range(0, 2) != 0;
            clr_cnt       = $urandom_range(0, 63) == 0;
            rst           = $urandom_range(0, 299) != 0;
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sign_demux.md
# sign_demux

Inverse of the noise-path sign MUX stage. Accepts signed 16-bit two's-complement noise samples and decodes each into a sign bit and a 16-bit unsigned magnitude. Decoded samples are buffered in a small FIFO and handed downstream over a valid/ready handshake, and the block keeps saturating positive/negative sample counters. It sits at the Gaussian noise generator output, feeding analysis and loopback logic that works in sign/magnitude form.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_W, 16: width of each sample counter.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data holds a sample.
- in_ready  out  1  block can accept a sample this cycle; registered.
- in_data  in  16  two's-complement noise sample.
- out_valid  out  1  FIFO head holds a decoded sample.
- out_ready  in  1  downstream takes the head this cycle.
- out_sign  out  1  sign of the head sample (1 = negative).
- out_mag  out  16  unsigned magnitude of the head sample.
- clr_cnt  in  1  synchronous clear of both counters.
- pos_cnt  out  CNT_W  count of popped samples with sign 0 (includes zero).
- neg_cnt  out  CNT_W  count of popped samples with sign 1.

## Operation
- Decode on accept:
  - out_sign = in_data[15].
  - out_mag = in_data[15] ? (~in_data + 1) : in_data, taken mod 2^16.
  - 0x8000 decodes to sign 1, mag 0x8000; no saturation.
  - 0x0000 decodes to sign 0, mag 0.
- Push: in_valid && in_ready writes the 17-bit entry {sign, mag} at the write pointer, then the write pointer increments.
- Pop: out_valid && out_ready advances the read pointer.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a count of log2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- out_valid = (count != 0). out_sign/out_mag are driven from the entry at the read pointer; when empty, they show that stale entry.
- in_ready register:
  - next value = (next_count < DEPTH), where next_count is count after this edge's push/pop.
  - When full, in_ready is 0 even if out_ready is 1 that cycle. There is no combinational ready path.
- Counters: on a pop, increment pos_cnt or neg_cnt according to the popped entry's sign.
  - Counters saturate at 2^CNT_W − 1.
  - clr_cnt = 1 zeroes both counters and wins over a same-cycle pop; that pop is not counted.
- Reset (rst = 0 at an edge):
  - count, pointers, all FIFO entries, pos_cnt, neg_cnt, in_ready, out_valid, out_sign and out_mag go to 0.
  - Reset mid-operation discards buffered samples, and in-flight handshakes in that cycle are ignored.

## Timing
- Reset values: every output 0.
- in_ready: 0 while rst = 0 and during the first post-reset cycle. It becomes 1 after the first edge with rst = 1.
- Latency: a sample accepted at edge k appears at the output with out_valid = 1 immediately after edge k, so it can be popped at edge k+1.
- Throughput: one sample per cycle when out_ready is held high.
- After a pop from a full FIFO at edge k, in_ready rises after edge k and a new push is possible at edge k+1.
- Counters update at the pop edge and are visible the cycle after.

## Test plan
- Decode set: push 0xAF0C, 0x50F4, 0x8000, 0x0000, 0xFFFF with out_ready = 1.
  - Outputs in order: (1,0x50F4), (0,0x50F4), (1,0x8000), (0,0x0000), (1,0x0001).
  - Afterwards pos_cnt = 2, neg_cnt = 3.
- Back-pressure, DEPTH = 4, out_ready = 0:
  - After 4 accepts, in_ready = 0; a 5th sample is held and not written.
  - Raising out_ready for one cycle pops entry 0 and returns in_ready to 1 the next cycle. The 5th sample is then accepted, and order is preserved across pointer wrap.
- Simultaneous push/pop at count 2 for 10 cycles: count stays 2, all samples emerge in order, and the pointers wrap at least twice.
- Counter saturation with CNT_W = 3: pop 9 negative samples → neg_cnt stays at 7, pos_cnt = 0. Then clr_cnt coincident with a pop → both counters 0.
- Reset mid-operation: with 3 entries buffered, drive rst = 0 for one edge.
  - Outputs all 0 and in_ready = 0.
  - One cycle after release, in_ready = 1 and no stale sample appears.
- Latency check: push 0x1234 at edge k into an empty FIFO → out_valid = 1 and out_mag = 0x1234 in the cycle after edge k.
